norm_shift: RTL and testbench

Pipelined normalizer directly downstream of the 55-bit leading-one priority encoder in the FP subtract datapath. It consumes the unnormalized mantissa difference together with the encoder's MSB index. It left-shifts the mantissa so the leading one lands in bit WIDTH-1, decrements the exponent by the shift amount, and flags zero, underflow and bad-index cases. A 3-stage pipeline with valid/ready handshake feeds the rounding stage.

---
 rtl/norm_shift.sv | 128 ++++++++++++
 tb/tb_norm_shift.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_shift.sv
// norm_shift: 3-stage leading-one normalizer; shifts the leading one to bit WIDTH-1,
// adjusts the exponent and flags zero / underflow / encoder-disagreement results.
module norm_shift #(
    parameter int WIDTH = 55,
    parameter int EXP_W = 11,
    parameter int MSB_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_diff,
    input  logic [MSB_W-1:0] in_msb,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_uf,
    output logic             out_err,
    output logic [CNT_W-1:0] uf_count
);
    logic             stall;
    logic             va_q, va_d;
    logic [WIDTH-1:0] diff_a_q, diff_a_d;
    logic [EXP_W-1:0] exp_a_q, exp_a_d;
    logic [MSB_W-1:0] msb_a_q, msb_a_d;
    logic [WIDTH-1:0] at_msb;
    logic             zero_a, err_a, uf_a;
    logic [MSB_W-1:0] shift_a;
    logic [EXP_W:0]   expd_a;
    logic             vb_q, vb_d;
    logic [WIDTH-1:0] mant_b_q, mant_b_d;
    logic [EXP_W:0]   expd_b_q, expd_b_d;
    logic             zero_b_q, zero_b_d, err_b_q, err_b_d, uf_b_q, uf_b_d;
    logic [2:0]       fine_b_q, fine_b_d;
    logic [WIDTH-1:0] mant_c;
    logic             kill_b;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_mant_q, out_mant_d;
    logic [EXP_W-1:0] out_exp_q, out_exp_d;
    logic             out_zero_q, out_zero_d, out_uf_q, out_uf_d, out_err_q, out_err_d;
    logic [CNT_W-1:0] uf_count_q, uf_count_d;

    always_comb begin
        stall    = out_valid_q && !out_ready;
        in_ready = !stall;
        va_d     = stall ? va_q : in_valid;
        diff_a_d = stall ? diff_a_q : in_diff;
        exp_a_d  = stall ? exp_a_q : in_exp;
        msb_a_d  = stall ? msb_a_q : in_msb;
        // Bounds check first so an out-of-range index never selects a real bit
        at_msb   = diff_a_q >> msb_a_q;
        zero_a   = ~|diff_a_q;
        err_a    = !zero_a && (msb_a_q > MSB_W'(WIDTH - 1) || !at_msb[0]);
        shift_a  = MSB_W'(WIDTH - 1) - msb_a_q;
        expd_a   = {1'b0, exp_a_q} - (EXP_W + 1)'(shift_a);
        uf_a     = !zero_a && !err_a && (expd_a[EXP_W] || expd_a == '0);
        vb_d     = stall ? vb_q : va_q;
        mant_b_d = stall ? mant_b_q : diff_a_q << {shift_a[MSB_W-1:3], 3'b000};
        expd_b_d = stall ? expd_b_q : expd_a;
        zero_b_d = stall ? zero_b_q : zero_a;
        err_b_d  = stall ? err_b_q : err_a;
        uf_b_d   = stall ? uf_b_q : uf_a;
        fine_b_d = stall ? fine_b_q : shift_a[2:0];
        mant_c   = mant_b_q << fine_b_q;
        kill_b   = err_b_q || zero_b_q || uf_b_q;
        out_valid_d = stall ? out_valid_q : vb_q;
        out_mant_d  = stall ? out_mant_q : (kill_b ? '0 : mant_c);
        out_exp_d   = stall ? out_exp_q : (kill_b ? '0 : expd_b_q[EXP_W-1:0]);
        out_err_d   = stall ? out_err_q : err_b_q;
        out_zero_d  = stall ? out_zero_q : zero_b_q;
        out_uf_d    = stall ? out_uf_q : uf_b_q;
        uf_count_d  = (out_valid_q && out_ready && out_uf_q && !(&uf_count_q)) ? uf_count_q + 1'b1 : uf_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va_q        <= 1'b0;
            diff_a_q    <= '0;
            exp_a_q     <= '0;
            msb_a_q     <= '0;
            vb_q        <= 1'b0;
            mant_b_q    <= '0;
            expd_b_q    <= '0;
            zero_b_q    <= 1'b0;
            err_b_q     <= 1'b0;
            uf_b_q      <= 1'b0;
            fine_b_q    <= '0;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
            out_uf_q    <= 1'b0;
            out_err_q   <= 1'b0;
            uf_count_q  <= '0;
        end else begin
            va_q        <= va_d;
            diff_a_q    <= diff_a_d;
            exp_a_q     <= exp_a_d;
            msb_a_q     <= msb_a_d;
            vb_q        <= vb_d;
            mant_b_q    <= mant_b_d;
            expd_b_q    <= expd_b_d;
            zero_b_q    <= zero_b_d;
            err_b_q     <= err_b_d;
            uf_b_q      <= uf_b_d;
            fine_b_q    <= fine_b_d;
            out_valid_q <= out_valid_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_zero_q  <= out_zero_d;
            out_uf_q    <= out_uf_d;
            out_err_q   <= out_err_d;
            uf_count_q  <= uf_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_zero  = out_zero_q;
    assign out_uf    = out_uf_q;
    assign out_err   = out_err_q;
    assign uf_count  = uf_count_q;
endmodule

// File: tb/tb_norm_shift.sv
// tb_norm_shift: directed table, backpressure, reset and randomized scoreboard checks
module tb_norm_shift;
    localparam int W = 55;
    localparam int E = 11;
    localparam int M = 6;
    localparam int C = 8;
    localparam logic [W-1:0] ONE54 = 55'h1 << 54;

    typedef struct packed {
        logic [W-1:0] mant;
        logic [E-1:0] oexp;
        logic         z;
        logic         uf;
        logic         err;
    } res_t;

    typedef struct {
        logic [W-1:0] diff;
        logic [M-1:0] msb;
        logic [E-1:0] iexp;
        res_t         want;
    } vec_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] in_diff = '0;
    logic [M-1:0] in_msb = '0;
    logic [E-1:0] in_exp = '0;
    logic         out_valid;
    logic         out_ready = 1;
    logic [W-1:0] out_mant;
    logic [E-1:0] out_exp;
    logic         out_zero, out_uf, out_err;
    logic [C-1:0] uf_count;

    int   checks = 0;
    int   fails = 0;
    int   pops = 0;
    res_t q[$];
    int   uf_model = 0;
    logic prev_stall = 0;
    logic [W-1:0] prev_mant;
    logic [E+3:0] prev_misc;
    logic done;

    norm_shift #(.WIDTH(W), .EXP_W(E), .MSB_W(M), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_diff(in_diff), .in_msb(in_msb), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
        .out_exp(out_exp), .out_zero(out_zero), .out_uf(out_uf), .out_err(out_err),
        .uf_count(uf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: full shift by (W-1-msb) in one step, exponent via integer arithmetic
    function automatic res_t model(logic [W-1:0] d, logic [M-1:0] m, logic [E-1:0] e);
        res_t r = '0;
        int   s;
        if (d == 0) r.z = 1;
        else if (int'(m) > W - 1) r.err = 1;
        else if (d[m] == 1'b0) r.err = 1;
        else begin
            s = W - 1 - int'(m);
            if (int'(e) - s <= 0) r.uf = 1;
            else begin
                r.mant = d << s;
                r.oexp = E'(int'(e) - s);
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        res_t w;
        if (!rst_n) begin
            q.delete();
            uf_model = 0;
            prev_stall = 0;
        end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            chk("uf_count", uf_count, uf_model);
            if (prev_stall) begin
                chk("stall_mant", out_mant, prev_mant);
                chk("stall_misc", {out_valid, out_exp, out_zero, out_uf, out_err}, prev_misc);
            end
            if (out_valid && out_ready) begin
                chk("spurious_out", q.size() == 0, 0);
                if (q.size() != 0) begin
                    w = q.pop_front();
                    pops++;
                    chk("sb_mant", out_mant, w.mant);
                    chk("sb_exp_flags", {out_exp, out_zero, out_uf, out_err}, {w.oexp, w.z, w.uf, w.err});
                    if (w.uf && uf_model < 2**C - 1) uf_model++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_diff, in_msb, in_exp));
            prev_stall = out_valid && !out_ready;
            prev_mant = out_mant;
            prev_misc = {out_valid, out_exp, out_zero, out_uf, out_err};
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [M-1:0] m, input logic [E-1:0] e);
        int   n = 0;
        logic ok;
        in_valid = 1;
        in_diff = d;
        in_msb = m;
        in_exp = e;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        in_valid = 0;
        chk("send_accept", ok, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic rnd_beat(output logic [W-1:0] d, output logic [M-1:0] m, output logic [E-1:0] e);
        int          r = $urandom_range(0, 19);
        int          lz = $urandom_range(0, W - 1);
        logic [63:0] x = {$urandom, $urandom};
        x = (x & ((64'd1 << lz) - 1)) | (64'd1 << lz);
        d = (r == 0) ? '0 : x[W-1:0];
        m = (r < 3) ? M'($urandom_range(0, 63)) : M'(lz);
        e = $urandom_range(0, 1) ? E'($urandom_range(0, 70)) : E'($urandom_range(0, 2047));
    endtask

    initial begin
        vec_t         tbl[11];
        int           n;
        int           p0;
        logic [W-1:0] d;
        logic [M-1:0] m;
        logic [E-1:0] e;
        tbl[0]  = '{55'h1, 6'd0, 11'd100, '{ONE54, 11'd46, 1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{{W{1'b1}}, 6'd54, 11'd1023, '{{W{1'b1}}, 11'd1023, 1'b0, 1'b0, 1'b0}};
        tbl[2]  = '{55'h0, 6'd0, 11'd1023, '{55'h0, 11'd0, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{55'h1, 6'd0, 11'd54, '{55'h0, 11'd0, 1'b0, 1'b1, 1'b0}};
        tbl[4]  = '{55'h1, 6'd0, 11'd55, '{ONE54, 11'd1, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{55'h4, 6'd5, 11'd100, '{55'h0, 11'd0, 1'b0, 1'b0, 1'b1}};
        tbl[6]  = '{55'h4, 6'd60, 11'd100, '{55'h0, 11'd0, 1'b0, 1'b0, 1'b1}};
        tbl[7]  = '{55'h0, 6'd60, 11'd5, '{55'h0, 11'd0, 1'b1, 1'b0, 1'b0}};
        tbl[8]  = '{55'h10, 6'd4, 11'd0, '{55'h0, 11'd0, 1'b0, 1'b1, 1'b0}};
        tbl[9]  = '{ONE54 | 55'h5, 6'd54, 11'd0, '{55'h0, 11'd0, 1'b0, 1'b1, 1'b0}};
        tbl[10] = '{55'h3ff, 6'd9, 11'd2047, '{55'h3ff << 45, 11'd2002, 1'b0, 1'b0, 1'b0}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_out", {out_mant, out_exp, out_zero, out_uf, out_err}, '0);
        chk("rst_ufcnt", uf_count, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].diff, tbl[i].msb, tbl[i].iexp);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 10);
            chk($sformatf("tbl%0d_latency", i), n, 3);
            chk($sformatf("tbl%0d_mant", i), out_mant, tbl[i].want.mant);
            chk($sformatf("tbl%0d_exp", i), out_exp, tbl[i].want.oexp);
            chk($sformatf("tbl%0d_flags", i), {out_zero, out_uf, out_err}, {tbl[i].want.z, tbl[i].want.uf, tbl[i].want.err});
            @(posedge clk);
            #1;
        end
        chk("tbl_ufcnt", uf_count, 3);

        p0 = pops;
        done = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    d = (ONE54 >> k) | W'(k);
                    send(d, M'(54 - k), E'(1000 + k));
                end
                done = 1;
            end
            begin
                int c = 0;
                while (!done) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    c++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        for (int c = 0; c < 40 && (q.size() != 0 || out_valid); c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        drain();
        chk("bp_count", pops - p0, 8);

        for (int k = 0; k < 3; k++) send(55'h1, 6'd0, 11'd20);
        rst_n = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ufcnt", uf_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        p0 = pops;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_stale", pops - p0, 0);

        done = 0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    rnd_beat(d, m, e);
                    send(d, m, e);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        out_ready = 1;
        drain();

        for (int k = 0; k < 2**C + 2; k++) send(55'h1, 6'd0, 11'd10);
        drain();
        @(posedge clk);
        #1;
        chk("uf_saturate", uf_count, 2**C - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
